// File: rtl/bft_pkg.sv
// BFT packet field layout, port identifiers and credit limits shared by leaf interface blocks.
package bft_pkg;

    localparam int unsigned PACKET_W    = 49;
    localparam int unsigned PAYLOAD_W   = 32;
    localparam int unsigned LEAF_W      = 5;
    localparam int unsigned PORT_W      = 4;
    localparam int unsigned ADDR_W      = 7;
    localparam int unsigned BRAM_ADDR_W = 7;

    localparam int unsigned PKT_VLD_BIT = 48;
    localparam int unsigned LEAF_LSB    = 43;
    localparam int unsigned PORT_LSB    = 39;
    localparam int unsigned ADDR_LSB    = 32;
    localparam int unsigned PAYLOAD_LSB = 0;

    localparam logic [PORT_W-1:0] CFG_PORT    = 4'd0;
    localparam logic [PORT_W-1:0] CREDIT_PORT = 4'd1;

    localparam int unsigned CREDIT_MAX = 1 << BRAM_ADDR_W;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_NEW,
        SEL_RESEND
    } out_sel_t;

endpackage

// File: rtl/leaf_out_packetizer_if.sv
// Stream/packet signals between the user kernel, the BFT leaf and the output packetizer.
interface leaf_out_packetizer_if #(
    parameter int unsigned PACKET_BITS  = 49,
    parameter int unsigned PAYLOAD_BITS = 32
);
    logic [PACKET_BITS-1:0]  din_leaf_bft2interface;
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic                    vld_user2interface;
    logic                    ack_interface2user;
    logic                    resend;
    logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;

    modport master (
        output din_leaf_bft2interface,
        output din_leaf_user2interface,
        output vld_user2interface,
        output resend,
        input  ack_interface2user,
        input  dout_leaf_interface2bft
    );

    modport slave (
        input  din_leaf_bft2interface,
        input  din_leaf_user2interface,
        input  vld_user2interface,
        input  resend,
        output ack_interface2user,
        output dout_leaf_interface2bft
    );
endinterface

// File: rtl/credit_counter.sv
// Saturating up/down credit counter: adds i_inc, subtracts one on i_dec, clamps at MAX.
module credit_counter
    import bft_pkg::*;
#(
    parameter int unsigned WIDTH = BRAM_ADDR_W + 1,
    parameter int unsigned MAX   = CREDIT_MAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;
    logic             w_dec;
    logic [WIDTH+1:0] w_sum;

    // Two guard bits hold count+inc without overflow before the clamp.
    always_comb begin
        w_dec = i_dec && (r_count != '0);
        w_sum = (WIDTH+2)'(r_count) + (WIDTH+2)'(i_inc) - (WIDTH+2)'(w_dec);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= WIDTH'(MAX);
        end else if (w_sum > (WIDTH+2)'(MAX)) begin
            r_count <= WIDTH'(MAX);
        end else begin
            r_count <= w_sum[WIDTH-1:0];
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/leaf_out_packetizer.sv
// BFT leaf output stage: wraps user words into packets, tracks destination credits,
// replays the last packet on resend and takes destination/credits in-band from the BFT.
module leaf_out_packetizer
    import bft_pkg::*;
#(
    parameter int unsigned PACKET_BITS        = PACKET_W,
    parameter int unsigned PAYLOAD_BITS       = PAYLOAD_W,
    parameter int unsigned NUM_LEAF_BITS      = LEAF_W,
    parameter int unsigned NUM_PORT_BITS      = PORT_W,
    parameter int unsigned NUM_ADDR_BITS      = ADDR_W,
    parameter int unsigned NUM_BRAM_ADDR_BITS = BRAM_ADDR_W
) (
    input logic                 clk,
    input logic                 reset,
    leaf_out_packetizer_if.slave bus
);
    localparam int unsigned CNT_W = NUM_BRAM_ADDR_BITS + 1;

    logic                      w_in_vld;
    logic [NUM_PORT_BITS-1:0]  w_in_port;
    logic [PAYLOAD_BITS-1:0]   w_in_payload;
    logic                      w_is_cfg;
    logic                      w_is_credit;
    logic [CNT_W-1:0]          w_credit_upd;
    logic [CNT_W-1:0]          w_credits;
    logic                      w_credit_zero;
    logic                      w_ack;
    logic [PACKET_BITS-1:0]    w_new_pkt;
    out_sel_t                  w_sel;
    logic                      w_unused_in;

    logic                      r_configured;
    logic [NUM_LEAF_BITS-1:0]  r_dest_leaf;
    logic [NUM_PORT_BITS-1:0]  r_dest_port;
    logic [NUM_ADDR_BITS-1:0]  r_addr_cnt;
    logic [PACKET_BITS-1:0]    r_last_pkt;
    logic                      r_last_vld;
    logic [PACKET_BITS-1:0]    r_dout;

    assign w_in_vld     = bus.din_leaf_bft2interface[PKT_VLD_BIT];
    assign w_in_port    = bus.din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    assign w_in_payload = bus.din_leaf_bft2interface[PAYLOAD_LSB +: PAYLOAD_BITS];
    assign w_is_cfg     = w_in_vld && (w_in_port == CFG_PORT);
    assign w_is_credit  = w_in_vld && (w_in_port == CREDIT_PORT);
    assign w_credit_upd = w_is_credit ? w_in_payload[CNT_W-1:0] : '0;

    // Incoming leaf/addr fields and upper payload bits carry nothing for this stage.
    assign w_unused_in = ^{bus.din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS],
                           bus.din_leaf_bft2interface[ADDR_LSB +: NUM_ADDR_BITS],
                           w_in_payload[PAYLOAD_BITS-1:NUM_LEAF_BITS+NUM_PORT_BITS],
                           w_credits};

    assign w_ack = bus.vld_user2interface & r_configured & ~w_credit_zero & ~bus.resend;
    assign bus.ack_interface2user      = w_ack;
    assign bus.dout_leaf_interface2bft = r_dout;

    assign w_new_pkt = {1'b1, r_dest_leaf, r_dest_port, r_addr_cnt, bus.din_leaf_user2interface};

    always_comb begin
        w_sel = SEL_IDLE;
        if (bus.resend && r_last_vld) begin
            w_sel = SEL_RESEND;
        end else if (w_ack) begin
            w_sel = SEL_NEW;
        end
    end

    credit_counter #(
        .WIDTH (CNT_W),
        .MAX   (CREDIT_MAX)
    ) u_credit (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_credit_upd),
        .i_dec   (w_ack),
        .o_count (w_credits),
        .o_zero  (w_credit_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_configured <= 1'b0;
            r_dest_leaf  <= '0;
            r_dest_port  <= '0;
            r_addr_cnt   <= '0;
            r_last_pkt   <= '0;
            r_last_vld   <= 1'b0;
            r_dout       <= '0;
        end else begin
            if (w_is_cfg) begin
                r_dest_leaf  <= w_in_payload[NUM_PORT_BITS +: NUM_LEAF_BITS];
                r_dest_port  <= w_in_payload[0 +: NUM_PORT_BITS];
                r_configured <= 1'b1;
            end
            case (w_sel)
                SEL_NEW: begin
                    r_dout     <= w_new_pkt;
                    r_last_pkt <= w_new_pkt;
                    r_last_vld <= 1'b1;
                    r_addr_cnt <= r_addr_cnt + 1'b1;
                end
                SEL_RESEND: begin
                    r_dout     <= r_last_pkt;
                    r_last_vld <= 1'b1;
                end
                default: begin
                    r_dout     <= '0;
                    r_last_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Directed self-checking bench for leaf_out_packetizer.
module tb_leaf_out_packetizer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leaf_out_packetizer_if bus ();

    leaf_out_packetizer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] credits_obs;
    assign credits_obs = dut.w_credits;

    function automatic logic [48:0] exp_pkt(input logic [6:0] addr, input logic [31:0] w);
        return {1'b1, 5'd5, 4'd3, addr, w};
    endfunction

    function automatic logic [48:0] cfg_pkt(input logic [31:0] p);
        return {1'b1, 5'd9, 4'd0, 7'd33, p};
    endfunction

    function automatic logic [48:0] credit_pkt(input logic [7:0] n);
        return {1'b1, 5'd9, 4'd1, 7'd33, 24'hABCDEF, n};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.din_leaf_bft2interface  = '0;
        bus.din_leaf_user2interface = '0;
        bus.vld_user2interface      = 1'b0;
        bus.resend                  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic configure(input logic [31:0] p);
        bus.din_leaf_bft2interface = cfg_pkt(p);
        step();
        bus.din_leaf_bft2interface = '0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== 49'd0)
            $display("FAIL reset_dout: got %h expected 0", bus.dout_leaf_interface2bft);
        else pass_cnt++;
        total_cnt++;
        if (credits_obs !== 8'd128)
            $display("FAIL reset_credits: got %0d expected 128", credits_obs);
        else pass_cnt++;
        bus.vld_user2interface      = 1'b1;
        bus.din_leaf_user2interface = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b0)
            $display("FAIL reset_ack: got %b expected 0", bus.ack_interface2user);
        else pass_cnt++;
        bus.vld_user2interface = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] w;
        do_reset();
        configure(32'h0000_0053);
        for (int i = 0; i < 3; i++) begin
            w = 32'hA5A5_0000 | 32'(i);
            bus.vld_user2interface      = 1'b1;
            bus.din_leaf_user2interface = w;
            #1;
            total_cnt++;
            if (bus.ack_interface2user !== 1'b1)
                $display("FAIL basic_ack[%0d]: got %b expected 1", i, bus.ack_interface2user);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus.dout_leaf_interface2bft !== exp_pkt(7'(i), w))
                $display("FAIL basic_pkt[%0d]: got %h expected %h", i,
                         bus.dout_leaf_interface2bft, exp_pkt(7'(i), w));
            else pass_cnt++;
        end
        bus.vld_user2interface = 1'b0;
        step();
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== 49'd0)
            $display("FAIL basic_idle: got %h expected 0", bus.dout_leaf_interface2bft);
        else pass_cnt++;
        total_cnt++;
        if (credits_obs !== 8'd125)
            $display("FAIL basic_credits: got %0d expected 125", credits_obs);
        else pass_cnt++;
    endtask

    task automatic test_no_config();
        do_reset();
        bus.vld_user2interface      = 1'b1;
        bus.din_leaf_user2interface = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            #1;
            total_cnt++;
            if (bus.ack_interface2user !== 1'b0 || bus.dout_leaf_interface2bft !== 49'd0)
                $display("FAIL noconfig[%0d]: got ack=%b dout=%h expected ack=0 dout=0", i,
                         bus.ack_interface2user, bus.dout_leaf_interface2bft);
            else pass_cnt++;
            step();
        end
        bus.din_leaf_bft2interface = cfg_pkt(32'h0000_0053);
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b0)
            $display("FAIL noconfig_cfg_cycle_ack: got %b expected 0", bus.ack_interface2user);
        else pass_cnt++;
        step();
        bus.din_leaf_bft2interface = '0;
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b1)
            $display("FAIL noconfig_after_cfg_ack: got %b expected 1", bus.ack_interface2user);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== exp_pkt(7'd0, 32'h1234_5678))
            $display("FAIL noconfig_first_pkt: got %h expected %h",
                     bus.dout_leaf_interface2bft, exp_pkt(7'd0, 32'h1234_5678));
        else pass_cnt++;
        bus.vld_user2interface = 1'b0;
        step();
    endtask

    task automatic test_credit_exhaust();
        logic [31:0] w;
        do_reset();
        configure(32'h0000_0053);
        bus.vld_user2interface = 1'b1;
        for (int i = 0; i < 128; i++) begin
            w = 32'h0000_1000 + 32'(i);
            bus.din_leaf_user2interface = w;
            #1;
            total_cnt++;
            if (bus.ack_interface2user !== 1'b1)
                $display("FAIL exhaust_ack[%0d]: got %b expected 1", i, bus.ack_interface2user);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus.dout_leaf_interface2bft !== exp_pkt(7'(i), w))
                $display("FAIL exhaust_pkt[%0d]: got %h expected %h", i,
                         bus.dout_leaf_interface2bft, exp_pkt(7'(i), w));
            else pass_cnt++;
        end
        bus.din_leaf_user2interface = 32'hFFFF_0000;
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b0)
            $display("FAIL exhaust_ack_129: got %b expected 0", bus.ack_interface2user);
        else pass_cnt++;
        total_cnt++;
        if (credits_obs !== 8'd0)
            $display("FAIL exhaust_credits: got %0d expected 0", credits_obs);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== 49'd0)
            $display("FAIL exhaust_stall_dout: got %h expected 0", bus.dout_leaf_interface2bft);
        else pass_cnt++;
        bus.din_leaf_bft2interface = credit_pkt(8'd64);
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b0)
            $display("FAIL exhaust_credit_cycle_ack: got %b expected 0", bus.ack_interface2user);
        else pass_cnt++;
        step();
        bus.din_leaf_bft2interface = '0;
        total_cnt++;
        if (credits_obs !== 8'd64)
            $display("FAIL exhaust_refill: got %0d expected 64", credits_obs);
        else pass_cnt++;
        for (int j = 0; j < 64; j++) begin
            w = 32'h0000_2000 + 32'(j);
            bus.din_leaf_user2interface = w;
            #1;
            total_cnt++;
            if (bus.ack_interface2user !== 1'b1)
                $display("FAIL refill_ack[%0d]: got %b expected 1", j, bus.ack_interface2user);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus.dout_leaf_interface2bft !== exp_pkt(7'(j), w))
                $display("FAIL refill_pkt[%0d]: got %h expected %h", j,
                         bus.dout_leaf_interface2bft, exp_pkt(7'(j), w));
            else pass_cnt++;
        end
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b0)
            $display("FAIL refill_ack_65: got %b expected 0", bus.ack_interface2user);
        else pass_cnt++;
        bus.vld_user2interface = 1'b0;
        step();
    endtask

    task automatic test_resend();
        do_reset();
        configure(32'h0000_0053);
        bus.vld_user2interface = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.din_leaf_user2interface = 32'hC0DE_0000 + 32'(i);
            step();
        end
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== exp_pkt(7'd4, 32'hC0DE_0004))
            $display("FAIL resend_orig: got %h expected %h",
                     bus.dout_leaf_interface2bft, exp_pkt(7'd4, 32'hC0DE_0004));
        else pass_cnt++;
        bus.resend                  = 1'b1;
        bus.din_leaf_user2interface = 32'hBEEF_0005;
        for (int k = 0; k < 2; k++) begin
            #1;
            total_cnt++;
            if (bus.ack_interface2user !== 1'b0)
                $display("FAIL resend_ack[%0d]: got %b expected 0", k, bus.ack_interface2user);
            else pass_cnt++;
            step();
            total_cnt++;
            if (bus.dout_leaf_interface2bft !== exp_pkt(7'd4, 32'hC0DE_0004))
                $display("FAIL resend_pkt[%0d]: got %h expected %h", k,
                         bus.dout_leaf_interface2bft, exp_pkt(7'd4, 32'hC0DE_0004));
            else pass_cnt++;
        end
        bus.resend = 1'b0;
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b1)
            $display("FAIL resend_resume_ack: got %b expected 1", bus.ack_interface2user);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== exp_pkt(7'd5, 32'hBEEF_0005))
            $display("FAIL resend_next_pkt: got %h expected %h",
                     bus.dout_leaf_interface2bft, exp_pkt(7'd5, 32'hBEEF_0005));
        else pass_cnt++;
        total_cnt++;
        if (credits_obs !== 8'd122)
            $display("FAIL resend_credits: got %0d expected 122", credits_obs);
        else pass_cnt++;
        bus.vld_user2interface = 1'b0;
        step();
        bus.resend = 1'b1;
        step();
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== 49'd0)
            $display("FAIL resend_after_idle: got %h expected 0", bus.dout_leaf_interface2bft);
        else pass_cnt++;
        bus.resend = 1'b0;
        step();
    endtask

    task automatic test_credit_sat();
        do_reset();
        configure(32'h0000_0053);
        bus.vld_user2interface = 1'b1;
        for (int i = 0; i < 8; i++) step();
        total_cnt++;
        if (credits_obs !== 8'd120)
            $display("FAIL sat_pre: got %0d expected 120", credits_obs);
        else pass_cnt++;
        bus.din_leaf_bft2interface = credit_pkt(8'd10);
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b1)
            $display("FAIL sat_simul_ack: got %b expected 1", bus.ack_interface2user);
        else pass_cnt++;
        step();
        bus.din_leaf_bft2interface = '0;
        total_cnt++;
        if (credits_obs !== 8'd128)
            $display("FAIL sat_120: got %0d expected 128", credits_obs);
        else pass_cnt++;
        for (int i = 0; i < 78; i++) step();
        total_cnt++;
        if (credits_obs !== 8'd50)
            $display("FAIL sat_drain: got %0d expected 50", credits_obs);
        else pass_cnt++;
        bus.din_leaf_bft2interface = credit_pkt(8'd10);
        step();
        bus.din_leaf_bft2interface = '0;
        total_cnt++;
        if (credits_obs !== 8'd59)
            $display("FAIL sat_50: got %0d expected 59", credits_obs);
        else pass_cnt++;
        bus.vld_user2interface     = 1'b0;
        bus.din_leaf_bft2interface = credit_pkt(8'd255);
        step();
        total_cnt++;
        if (credits_obs !== 8'd128)
            $display("FAIL sat_255: got %0d expected 128", credits_obs);
        else pass_cnt++;
        bus.vld_user2interface     = 1'b1;
        bus.din_leaf_bft2interface = {1'b1, 5'd0, 4'd2, 7'd0, 32'h0000_0005};
        step();
        bus.vld_user2interface     = 1'b0;
        bus.din_leaf_bft2interface = {1'b0, 5'd0, 4'd1, 7'd0, 32'h0000_0005};
        step();
        bus.din_leaf_bft2interface = '0;
        total_cnt++;
        if (credits_obs !== 8'd127)
            $display("FAIL sat_ignored_pkts: got %0d expected 127", credits_obs);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        configure(32'h0000_0053);
        bus.vld_user2interface      = 1'b1;
        bus.din_leaf_user2interface = 32'h5555_AAAA;
        step();
        step();
        bus.resend = 1'b1;
        reset      = 1'b1;
        step();
        reset = 1'b0;
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== 49'd0)
            $display("FAIL rstmid_dout: got %h expected 0", bus.dout_leaf_interface2bft);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.dout_leaf_interface2bft !== 49'd0)
            $display("FAIL rstmid_no_reemit: got %h expected 0", bus.dout_leaf_interface2bft);
        else pass_cnt++;
        bus.resend = 1'b0;
        #1;
        total_cnt++;
        if (bus.ack_interface2user !== 1'b0)
            $display("FAIL rstmid_cfg_lost: got %b expected 0", bus.ack_interface2user);
        else pass_cnt++;
        total_cnt++;
        if (credits_obs !== 8'd128)
            $display("FAIL rstmid_credits: got %0d expected 128", credits_obs);
        else pass_cnt++;
        bus.vld_user2interface = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_no_config();
        test_credit_exhaust();
        test_resend();
        test_credit_sat();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
